// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator: resolves A vs B one bit per clock, LSB first.
// Define SIGNED_CMP_EN for a two's-complement compare; the default build is unsigned.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             ready,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CNT_W-1:0] cnt;
  logic             g, e, l;
  logic             swap;
  logic [2:0]       gel_nxt;

  // One cascade step. A difference at the current bit overrides everything
  // resolved at lower bits; equal bits carry the lower-order verdict upward.
  function automatic logic [2:0] gel_step(input logic a, input logic b,
                                          input logic g_in, input logic e_in,
                                          input logic l_in, input logic swp);
    logic same, a_eff, b_eff;
    same  = ~(a ^ b);
    a_eff = swp ? b : a;
    b_eff = swp ? a : b;
    return {(a_eff & ~b_eff) | (same & g_in),
            same & e_in,
            (~a_eff & b_eff) | (same & l_in)};
  endfunction

`ifdef SIGNED_CMP_EN
  // The sign bit carries negative weight, so a set MSB makes that operand smaller.
  assign swap = (cnt == CNT_LAST);
`else
  assign swap = 1'b0;
`endif

  assign gel_nxt = gel_step(a_sr[0], b_sr[0], g, e, l, swap);
  assign ready   = (state == IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      cnt   <= '0;
      g     <= 1'b0;
      e     <= 1'b0;
      l     <= 1'b0;
      done  <= 1'b0;
      gt    <= 1'b0;
      eq    <= 1'b0;
      lt    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a_in;
            b_sr <= b_in;
            g    <= 1'b0;
            e    <= 1'b1;
            l    <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          {g, e, l} <= gel_nxt;
          a_sr      <= a_sr >> 1;
          b_sr      <= b_sr >> 1;
          cnt       <= cnt + CNT_W'(1);
        end
        DONE: begin
          gt   <= g;
          eq   <= e;
          lt   <= l;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
